// File: rtl/home_inventory_pkg.sv
// Shared constants and types for the home-inventory load-cell frontend.
// The ADC sequencer and the Wishbone register block both import this package.
package home_inventory_pkg;

    localparam int unsigned NUM_CH_MAX = 8;
    localparam int unsigned DATA_W     = 24;

    // ADC_CFG register field widths
    localparam int unsigned CFG_NUM_CH_W = 4;
    localparam int unsigned CFG_CONT_W   = 1;

    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StStore,
        StDone
    } scan_state_e;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Conversion request/acknowledge handshake between the scan sequencer and the ADC frontend.
// The sequencer side uses the master modport, the frontend the slave modport.
interface adc_scan_sequencer_if #(
    parameter int unsigned ChW   = 3,
    parameter int unsigned DataW = 24
);

    logic             conv_req;
    logic [ChW-1:0]   conv_ch;
    logic             conv_ack;
    logic [DataW-1:0] conv_data;

    modport master (
        output conv_req,
        output conv_ch,
        input  conv_ack,
        input  conv_data
    );

    modport slave (
        input  conv_req,
        input  conv_ch,
        output conv_ack,
        output conv_data
    );

endinterface

// File: rtl/adc_timeout_ctr.sv
// Per-channel acknowledge timeout counter: cleared on request, counts while waiting and
// raises tc_o once it has counted TimeoutCyc-1 waiting cycles.
module adc_timeout_ctr #(
    parameter int unsigned TimeoutCyc = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = (TimeoutCyc > 2) ? $clog2(TimeoutCyc) : 1;
    localparam logic [CntW-1:0] TcVal = CntW'(TimeoutCyc - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TcVal);

    // Holds at the terminal value so a late ack can never see the counter wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Steps through ADC channels 0..n-1 over the conversion handshake, writes each sample into
// the raw register file and reports frame completion or acknowledge timeout.
module adc_scan_sequencer
    import home_inventory_pkg::*;
#(
    parameter int unsigned NumChMax   = NUM_CH_MAX,
    parameter int unsigned ChW        = $clog2(NumChMax),
    parameter int unsigned DataW      = DATA_W,
    parameter int unsigned TimeoutCyc = 1024
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic                     ctrl_enable,
    input  logic                     start_i,
    input  logic [CFG_NUM_CH_W-1:0]  cfg_num_ch,
    input  logic                     cfg_continuous,
    adc_scan_sequencer_if.master     conv_io,
    output logic                     raw_we_o,
    output logic [ChW-1:0]           raw_ch_o,
    output logic [DataW-1:0]         raw_data_o,
    output logic                     busy_o,
    output logic                     done_pulse_o,
    output logic                     timeout_pulse_o,
    output logic [FRAME_CNT_W-1:0]   frame_cnt_o
);

    scan_state_e            state_q, state_d;
    logic [ChW-1:0]         ch_q, ch_d;
    logic [ChW-1:0]         last_ch_q, last_ch_d;
    logic [DataW-1:0]       sample_q, sample_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic           tmo_clr, tmo_en, tmo_tc;
    logic [ChW:0]   eff_n;
    logic           conv_req;
    logic [ChW-1:0] conv_ch;

    assign conv_io.conv_req = conv_req;
    assign conv_io.conv_ch  = conv_ch;
    assign frame_cnt_o      = frame_cnt_q;

    // Channel count clamped to what the register file can hold.
    always_comb begin
        if (32'(cfg_num_ch) > NumChMax) begin
            eff_n = (ChW+1)'(NumChMax);
        end else begin
            eff_n = (ChW+1)'(cfg_num_ch);
        end
    end

    adc_timeout_ctr #(
        .TimeoutCyc (TimeoutCyc)
    ) u_timeout_ctr (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .clr_i  (tmo_clr),
        .en_i   (tmo_en),
        .tc_o   (tmo_tc)
    );

    always_comb begin
        state_d         = state_q;
        ch_d            = ch_q;
        last_ch_d       = last_ch_q;
        sample_d        = sample_q;
        frame_cnt_d     = frame_cnt_q;
        tmo_clr         = 1'b0;
        tmo_en          = 1'b0;
        conv_req        = 1'b0;
        conv_ch         = '0;
        raw_we_o        = 1'b0;
        raw_ch_o        = '0;
        raw_data_o      = '0;
        busy_o          = 1'b0;
        done_pulse_o    = 1'b0;
        timeout_pulse_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && ctrl_enable && (eff_n != '0)) begin
                    last_ch_d = ChW'(eff_n - (ChW+1)'(1));
                    ch_d      = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                busy_o   = 1'b1;
                conv_req = 1'b1;
                conv_ch  = ch_q;
                tmo_clr  = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                busy_o   = 1'b1;
                conv_req = 1'b1;
                conv_ch  = ch_q;
                tmo_en   = 1'b1;
                // An ack on the terminal cycle still wins over the timeout.
                if (conv_io.conv_ack) begin
                    sample_d = conv_io.conv_data;
                    state_d  = StStore;
                end else if (tmo_tc) begin
                    timeout_pulse_o = 1'b1;
                    state_d         = StIdle;
                end
            end
            StStore: begin
                busy_o     = 1'b1;
                raw_we_o   = 1'b1;
                raw_ch_o   = ch_q;
                raw_data_o = sample_q;
                if (ch_q == last_ch_q) begin
                    state_d = StDone;
                end else begin
                    ch_d    = ch_q + ChW'(1);
                    state_d = StReq;
                end
            end
            StDone: begin
                busy_o       = 1'b1;
                done_pulse_o = 1'b1;
                frame_cnt_d  = frame_cnt_q + FRAME_CNT_W'(1);
                if (cfg_continuous) begin
                    ch_d    = '0;
                    state_d = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disable aborts the scan: nothing is stored, counted or pulsed on the way out.
        if ((state_q != StIdle) && !ctrl_enable) begin
            state_d         = StIdle;
            ch_d            = '0;
            sample_d        = sample_q;
            frame_cnt_d     = frame_cnt_q;
            raw_we_o        = 1'b0;
            raw_ch_o        = '0;
            raw_data_o      = '0;
            done_pulse_o    = 1'b0;
            timeout_pulse_o = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            last_ch_q   <= '0;
            sample_q    <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            last_ch_q   <= last_ch_d;
            sample_q    <= sample_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer: a cycle-accurate vector table for one frame,
// then directed sequences against a simple ADC frontend responder.
module tb_adc_scan_sequencer;
    import home_inventory_pkg::*;

    localparam int unsigned ChW        = 3;
    localparam int unsigned DataW      = 24;
    localparam int unsigned TimeoutCyc = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ctrl_enable;
    logic             start_i;
    logic [3:0]       cfg_num_ch;
    logic             cfg_continuous;
    logic             raw_we;
    logic [ChW-1:0]   raw_ch;
    logic [DataW-1:0] raw_data;
    logic             busy;
    logic             done_pulse;
    logic             timeout_pulse;
    logic [15:0]      frame_cnt;

    bit               use_resp = 1'b0;
    logic             tbl_ack  = 1'b0;
    logic [DataW-1:0] tbl_data = '0;
    logic             resp_ack;
    logic [DataW-1:0] resp_data;
    int               resp_delay = 2;
    int               noack_ch   = -1;

    adc_scan_sequencer_if #(.ChW(ChW), .DataW(DataW)) conv_if ();

    assign conv_if.conv_ack  = use_resp ? resp_ack : tbl_ack;
    assign conv_if.conv_data = use_resp ? resp_data : tbl_data;

    adc_scan_sequencer #(
        .NumChMax   (8),
        .ChW        (ChW),
        .DataW      (DataW),
        .TimeoutCyc (TimeoutCyc)
    ) dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .ctrl_enable     (ctrl_enable),
        .start_i         (start_i),
        .cfg_num_ch      (cfg_num_ch),
        .cfg_continuous  (cfg_continuous),
        .conv_io         (conv_if),
        .raw_we_o        (raw_we),
        .raw_ch_o        (raw_ch),
        .raw_data_o      (raw_data),
        .busy_o          (busy),
        .done_pulse_o    (done_pulse),
        .timeout_pulse_o (timeout_pulse),
        .frame_cnt_o     (frame_cnt)
    );

    always #5 clk = ~clk;

    // Frontend model: acks resp_delay cycles after the request rises, data = 0x100 + channel.
    initial begin
        int age;
        age       = 0;
        resp_ack  = 1'b0;
        resp_data = '0;
        forever begin
            @(negedge clk);
            if (conv_if.conv_req) begin
                age++;
                if (age == resp_delay + 1 && int'(conv_if.conv_ch) != noack_ch) begin
                    resp_ack  = 1'b1;
                    resp_data = DataW'(32'h100 + 32'(conv_if.conv_ch));
                end else begin
                    resp_ack = 1'b0;
                end
            end else begin
                age      = 0;
                resp_ack = 1'b0;
            end
        end
    end

    int   cyc = 0;
    int   done_cnt = 0;
    int   tmo_cnt = 0;
    int   busy_cyc = 0;
    int   tmo_cyc = -1;
    int   done_cyc[$];
    int   wr_ch[$];
    int   wr_data[$];
    int   req_rise_cyc[8];
    logic req_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (raw_we) begin
                wr_ch.push_back(int'(raw_ch));
                wr_data.push_back(int'(raw_data));
            end
            if (done_pulse) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            if (timeout_pulse) begin
                tmo_cnt++;
                tmo_cyc = cyc;
            end
            if (busy) busy_cyc++;
            if (conv_if.conv_req && !req_prev) req_rise_cyc[conv_if.conv_ch] = cyc;
            req_prev = conv_if.conv_req;
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] outs();
        return {13'd0, conv_if.conv_req, conv_if.conv_ch, raw_we, raw_ch, raw_data,
                busy, done_pulse, timeout_pulse, frame_cnt};
    endfunction

    typedef struct {
        logic             start;
        logic             ack;
        logic [DataW-1:0] data;
        logic             req;
        logic [ChW-1:0]   ch;
        logic             we;
        logic [ChW-1:0]   rch;
        logic [DataW-1:0] rdata;
        logic             busy;
        logic             done;
        logic [15:0]      fcnt;
    } vec_t;

    function automatic vec_t mk(logic start, logic ack, logic [DataW-1:0] data, logic req,
                                logic [ChW-1:0] ch, logic we, logic [DataW-1:0] rdata,
                                logic bsy, logic done, logic [15:0] fcnt);
        vec_t v;
        v.start = start;
        v.ack   = ack;
        v.data  = data;
        v.req   = req;
        v.ch    = req ? ch : '0;
        v.we    = we;
        v.rch   = we ? ch : '0;
        v.rdata = rdata;
        v.busy  = bsy;
        v.done  = done;
        v.fcnt  = fcnt;
        return v;
    endfunction

    function automatic logic [63:0] exp_pack(vec_t v);
        return {13'd0, v.req, v.ch, v.we, v.rch, v.rdata, v.busy, v.done, 1'b0, v.fcnt};
    endfunction

    vec_t vecs[$];

    initial begin
        int w0, d0, t0, b0, dc0, seen, n;
        logic [DataW-1:0] dat;

        // One 4-channel frame, ack two cycles after each request rises.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 4; c++) begin
            dat = DataW'(32'h100 + c);
            vecs.push_back(mk(0, 0, 0,   1, ChW'(c), 0, 0,   1, 0, 0));
            vecs.push_back(mk(0, 0, 0,   1, ChW'(c), 0, 0,   1, 0, 0));
            vecs.push_back(mk(0, 1, dat, 1, ChW'(c), 0, 0,   1, 0, 0));
            vecs.push_back(mk(0, 0, 0,   0, ChW'(c), 1, dat, 1, 0, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 24'h5a5a5a, 0, 0, 0, 0, 0, 0, 1));

        rst_n          = 1'b0;
        ctrl_enable    = 1'b1;
        start_i        = 1'b0;
        cfg_num_ch     = 4'd4;
        cfg_continuous = 1'b0;
        step();
        step();
        check("reset", outs(), 64'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            start_i = vecs[i].start;
            tbl_ack  = vecs[i].ack;
            tbl_data = vecs[i].data;
            #1;
            check($sformatf("vec%0d", i), outs(), exp_pack(vecs[i]));
            step();
        end
        start_i  = 1'b0;
        tbl_ack  = 1'b0;
        use_resp = 1'b1;

        // cfg_num_ch = 0: start ignored.
        cfg_num_ch = 4'd0;
        b0 = busy_cyc; d0 = done_cnt; t0 = tmo_cnt; w0 = wr_ch.size();
        pulse_start();
        repeat (4) step();
        check("zero_busy", 64'(busy_cyc - b0), 64'd0);
        check("zero_pulses", 64'((done_cnt - d0) + (tmo_cnt - t0) + (wr_ch.size() - w0)), 64'd0);

        // cfg_num_ch = 15 clamps to 8 channels.
        cfg_num_ch = 4'd15;
        resp_delay = 1;
        d0 = done_cnt; w0 = wr_ch.size();
        pulse_start();
        wait_idle("clamp", 200);
        check("clamp_writes", 64'(wr_ch.size() - w0), 64'd8);
        for (int i = 0; i < 8 && w0 + i < wr_ch.size(); i++) begin
            check($sformatf("clamp_wr%0d", i), {32'(wr_ch[w0+i]), 32'(wr_data[w0+i])},
                  {32'(i), 32'(32'h100 + i)});
        end
        check("clamp_done", 64'(done_cnt - d0), 64'd1);
        check("clamp_fcnt", 64'(frame_cnt), 64'd2);

        // Channel 1 never acked.
        cfg_num_ch = 4'd4;
        resp_delay = 2;
        noack_ch   = 1;
        d0 = done_cnt; t0 = tmo_cnt; w0 = wr_ch.size();
        pulse_start();
        wait_idle("tmo", 200);
        check("tmo_writes", 64'(wr_ch.size() - w0), 64'd1);
        if (wr_ch.size() > w0) check("tmo_wr_ch0", 64'(wr_ch[w0]), 64'd0);
        check("tmo_pulses", 64'(tmo_cnt - t0), 64'd1);
        check("tmo_latency", 64'(tmo_cyc - req_rise_cyc[1]), 64'd16);
        check("tmo_no_done", 64'(done_cnt - d0), 64'd0);
        check("tmo_fcnt", 64'(frame_cnt), 64'd2);
        noack_ch = -1;

        // Ack lands on the terminal cycle.
        cfg_num_ch = 4'd1;
        resp_delay = 16;
        d0 = done_cnt; t0 = tmo_cnt; w0 = wr_ch.size();
        pulse_start();
        wait_idle("race", 200);
        check("race_writes", 64'(wr_ch.size() - w0), 64'd1);
        if (wr_ch.size() > w0) check("race_data", 64'(wr_data[w0]), 64'h100);
        check("race_no_tmo", 64'(tmo_cnt - t0), 64'd0);
        check("race_done", 64'(done_cnt - d0), 64'd1);
        check("race_fcnt", 64'(frame_cnt), 64'd3);

        // Disable while waiting on ch2, same cycle as its ack.
        cfg_num_ch = 4'd4;
        resp_delay = 1;
        d0 = done_cnt; w0 = wr_ch.size();
        pulse_start();
        n = 0;
        while (!(conv_if.conv_req && conv_if.conv_ch == 3'd2) && n < 50) begin
            step();
            n++;
        end
        check("abort_reach_ch2", 64'(conv_if.conv_req), 64'd1);
        step();
        ctrl_enable = 1'b0;
        #1;
        check("abort_req_hold", 64'(conv_if.conv_req), 64'd1);
        step();
        check("abort_req_fall", {62'd0, conv_if.conv_req, busy}, 64'd0);
        repeat (3) step();
        check("abort_writes", 64'(wr_ch.size() - w0), 64'd2);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        ctrl_enable = 1'b1;
        step();

        // Second start mid-scan is ignored.
        cfg_num_ch = 4'd3;
        resp_delay = 2;
        d0 = done_cnt; w0 = wr_ch.size();
        pulse_start();
        repeat (5) step();
        pulse_start();
        wait_idle("retrig", 100);
        b0 = busy_cyc;
        repeat (10) step();
        check("retrig_not_queued", 64'(busy_cyc - b0), 64'd0);
        check("retrig_done", 64'(done_cnt - d0), 64'd1);
        check("retrig_writes", 64'(wr_ch.size() - w0), 64'd3);
        check("retrig_fcnt", 64'(frame_cnt), 64'd4);

        // Continuous mode, 2 channels, stopped after the third frame.
        cfg_num_ch     = 4'd2;
        cfg_continuous = 1'b1;
        resp_delay     = 1;
        dc0 = done_cyc.size(); w0 = wr_ch.size();
        pulse_start();
        seen = 0;
        n    = 0;
        while (seen < 3 && n < 200) begin
            step();
            n++;
            if (done_pulse) seen++;
        end
        cfg_continuous = 1'b0;
        wait_idle("cont", 50);
        check("cont_frames", 64'(seen), 64'd3);
        if (done_cyc.size() >= dc0 + 3) begin
            check("cont_gap1", 64'(done_cyc[dc0+1] - done_cyc[dc0]), 64'd7);
            check("cont_gap2", 64'(done_cyc[dc0+2] - done_cyc[dc0+1]), 64'd7);
        end
        check("cont_writes", 64'(wr_ch.size() - w0), 64'd6);
        check("cont_fcnt", 64'(frame_cnt), 64'd7);

        // Asynchronous reset in WAIT.
        cfg_num_ch = 4'd4;
        resp_delay = 100;
        pulse_start();
        step();
        check("rst_in_wait", 64'(conv_if.conv_req), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", outs(), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_stays_idle", outs(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
